// File: rtl/fp_accumulator.sv
// fp_accumulator
//   Sequential IEEE-754 single-precision accumulator. Sums NUM_TERMS consecutive
//   products into one float through a shared align/add/normalise datapath
//   (4 cycles per term), then holds the sum on a valid/ready output.
//   Arithmetic scope: no denormals (exponent 0 is zero), no NaN/Inf,
//   truncation rounding, exact cancellation gives +0, overflow saturates to
//   sign|0x7F7FFFFF, underflow flushes to +0.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data carries a product
//   in_ready   product accepted this cycle (IDLE only)
//   in_data    IEEE-754 product
//   out_valid  out_data holds a completed sum
//   out_ready  consumer takes out_data
//   out_data   IEEE-754 sum of NUM_TERMS products
//   busy       high in any state other than IDLE
module fp_accumulator #(
    parameter int NUM_TERMS = 9,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [31:0]      r_acc;
    logic [31:0]      r_opB;
    logic [CNT_W-1:0] r_count;
    logic [23:0]      r_sigA;
    logic [23:0]      r_sigB;
    logic [7:0]       r_expA;
    logic             r_signA;
    logic             r_signB;
    logic [24:0]      r_sum;
    logic             r_sumSign;

    logic             w_lastTerm;

    // Align-stage wires
    logic [7:0]  w_accExp;
    logic [7:0]  w_bExp;
    logic [23:0] w_accSig;
    logic [23:0] w_bSig;
    logic        w_bIsA;
    logic [7:0]  w_expDiff;
    logic [23:0] w_bigSig;
    logic [23:0] w_smallSig;
    logic [23:0] w_alignedSmall;

    // Add-stage wires
    logic [24:0] w_sum;
    logic        w_sumSign;

    // Normalise-stage wires
    logic [4:0]         w_lz;
    logic [23:0]        w_shifted;
    logic signed [9:0]  w_expWide;
    logic [22:0]        w_frac;
    logic [31:0]        w_normResult;

    assign w_lastTerm = (r_count == CNT_W'(NUM_TERMS));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: fixed four-cycle walk per term, DONE after the last one
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_nextState = ALIGN;
            ALIGN:   w_nextState = ADD;
            ADD:     w_nextState = NORM;
            NORM:    w_nextState = w_lastTerm ? DONE : IDLE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs; in_ready is gated by rst_n so it reads 0 while reset is held
    always_comb begin
        in_ready  = (r_state == IDLE) && rst_n;
        out_valid = (r_state == DONE);
        out_data  = (r_state == DONE) ? r_acc : 32'd0;
        busy      = (r_state != IDLE);
    end

    // Align: an exponent field of 0 is zero, so its significand is forced to 0.
    // On an exponent tie the accumulator stays operand A.
    always_comb begin
        w_accExp = r_acc[30:23];
        w_bExp   = r_opB[30:23];
        w_accSig = (w_accExp != 8'd0) ? {1'b1, r_acc[22:0]} : 24'd0;
        w_bSig   = (w_bExp   != 8'd0) ? {1'b1, r_opB[22:0]} : 24'd0;
        w_bIsA   = (w_bExp > w_accExp);
        if (w_bIsA) begin
            w_expDiff  = w_bExp - w_accExp;
            w_bigSig   = w_bSig;
            w_smallSig = w_accSig;
        end else begin
            w_expDiff  = w_accExp - w_bExp;
            w_bigSig   = w_accSig;
            w_smallSig = w_bSig;
        end
        w_alignedSmall = (w_expDiff >= 8'd25) ? 24'd0 : (w_smallSig >> w_expDiff);
    end

    // Add: magnitude subtract keeps the sign of the larger operand
    always_comb begin
        w_sum     = '0;
        w_sumSign = r_signA;
        if (r_signA == r_signB) begin
            w_sum     = {1'b0, r_sigA} + {1'b0, r_sigB};
            w_sumSign = r_signA;
        end else if (r_sigA >= r_sigB) begin
            w_sum     = {1'b0, r_sigA - r_sigB};
            w_sumSign = r_signA;
        end else begin
            w_sum     = {1'b0, r_sigB - r_sigA};
            w_sumSign = r_signB;
        end
    end

    // Normalise: priority encoder finds the leading one (highest set bit wins).
    // Exponent is computed 10-bit signed so overflow and underflow are visible.
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (r_sum[i]) w_lz = 5'(23 - i);
        end
        w_shifted    = r_sum[23:0] << w_lz;
        w_expWide    = '0;
        w_frac       = '0;
        w_normResult = 32'd0;
        if (r_sum != 25'd0) begin
            if (r_sum[24]) begin
                w_expWide = 10'({2'b00, r_expA}) + 10'd1;
                w_frac    = r_sum[23:1];
            end else begin
                w_expWide = 10'({2'b00, r_expA}) - 10'({5'd0, w_lz});
                w_frac    = w_shifted[22:0];
            end
            if (w_expWide > 10'sd254) begin
                w_normResult = {r_sumSign, 31'h7F7FFFFF};
            end else if (w_expWide < 10'sd1) begin
                w_normResult = 32'd0;
            end else begin
                w_normResult = {r_sumSign, w_expWide[7:0], w_frac};
            end
        end
    end

    // Datapath registers; each stage updates only in its own state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= 32'd0;
            r_opB     <= 32'd0;
            r_count   <= '0;
            r_sigA    <= '0;
            r_sigB    <= '0;
            r_expA    <= '0;
            r_signA   <= 1'b0;
            r_signB   <= 1'b0;
            r_sum     <= '0;
            r_sumSign <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opB   <= in_data;
                        r_count <= r_count + 1'b1;
                    end
                end
                ALIGN: begin
                    r_sigA  <= w_bigSig;
                    r_sigB  <= w_alignedSmall;
                    r_expA  <= w_bIsA ? w_bExp : w_accExp;
                    r_signA <= w_bIsA ? r_opB[31] : r_acc[31];
                    r_signB <= w_bIsA ? r_acc[31] : r_opB[31];
                end
                ADD: begin
                    r_sum     <= w_sum;
                    r_sumSign <= w_sumSign;
                end
                NORM: begin
                    r_acc <= w_normResult;
                end
                DONE: begin
                    if (out_ready) begin
                        r_acc   <= 32'd0;
                        r_count <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator
//   Directed bench for fp_accumulator with NUM_TERMS=3. Expected sums are
//   queued when a group is issued; a monitor pops and compares on every
//   out_valid&out_ready handshake.
module tb_fp_accumulator;

    localparam int NT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;
    logic [31:0] expQ[$];

    fp_accumulator #(.NUM_TERMS(NT), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, prints a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    endtask

    // Monitor: compare each delivered sum against the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpectedOutput: got 0x%08h expected no output", out_data);
            end else begin
                checkOutput("sum", out_data, expQ.pop_front());
            end
        end
    end

    // Offer one product and hold it until the DUT accepts it
    task automatic applyStimulus(input logic [31:0] data);
        int  waitCycles;
        bit  accepted;
        waitCycles = 0;
        accepted   = 1'b0;
        in_valid   = 1'b1;
        in_data    = data;
        while (!accepted && waitCycles < 50) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            else waitCycles++;
        end
        if (!accepted) begin
            checkCount++;
            $display("[TB] FAIL acceptTimeout: got in_ready=0 for 50 cycles expected 1");
        end else begin
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_data  = 32'd0;
    endtask

    task automatic sendGroup(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] expected);
        expQ.push_back(expected);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(c);
    endtask

    // Wait for all queued sums to be delivered and the DUT to return to IDLE
    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drainTimeout: got %0d pending sums expected 0", expQ.size());
            expQ.delete();
        end
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish within 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int readyEarly;
        int accepts;
        int handshakes;
        int lastReady;
        int minGap;
        bit sawValid;

        // Reset values while rst_n is held low
        #12;
        checkOutput("rstInReady",  {31'd0, in_ready},  32'd0);
        checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstOutData",  out_data,           32'd0);
        checkOutput("rstBusy",     {31'd0, busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idleInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("idleBusy",    {31'd0, busy},     32'd0);

        // Basic sums, cancellation, truncation
        sendGroup(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40C00000);
        sendGroup(32'h3FC00000, 32'hBFC00000, 32'h00000000, 32'h00000000);
        sendGroup(32'h4B800000, 32'h3F800000, 32'h3F800000, 32'h4B800000);
        // Exponent difference beyond 25 drops the small term
        sendGroup(32'h3F800000, 32'h30800000, 32'h3F800000, 32'h40000000);
        // Larger-magnitude new operand flips sign, then subtract
        sendGroup(32'h3F800000, 32'hC0400000, 32'h3E800000, 32'hBFE00000);
        // Overflow saturation, negative
        sendGroup(32'hFF7FFFFF, 32'hFF7FFFFF, 32'h00000000, 32'hFF7FFFFF);
        // Smallest normal result, then underflow flush
        sendGroup(32'h01400000, 32'h81000000, 32'h00000000, 32'h00800000);
        sendGroup(32'h00A00000, 32'h80800000, 32'h00000000, 32'h00000000);
        waitDrain();

        // Back-pressure: output held while out_ready=0, in_valid ignored
        out_ready = 1'b0;
        sendGroup(32'h40A00000, 32'hC0000000, 32'h3F000000, 32'h40600000);
        sawValid = 1'b0;
        for (int i = 0; i < 40 && !sawValid; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("holdSawValid", {31'd0, sawValid}, 32'd1);
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("holdValid",   {31'd0, out_valid}, 32'd1);
            checkOutput("holdData",    out_data,           32'h40600000);
            checkOutput("holdInReady", {31'd0, in_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        waitDrain();
        sendGroup(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000);
        waitDrain();

        // Continuous in_valid: one accept per four cycles, NT accepts per sum
        expQ.push_back(32'h40400000);
        expQ.push_back(32'h40400000);
        in_data    = 32'h3F800000;
        in_valid   = 1'b1;
        readyEarly = 0;
        accepts    = 0;
        handshakes = 0;
        lastReady  = -100;
        minGap     = 1000;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (i < 12) readyEarly++;
                accepts++;
                if (i - lastReady < minGap) minGap = i - lastReady;
                lastReady = i;
            end
            if (out_valid && out_ready) handshakes++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        checkOutput("streamReadyIn12", 32'(readyEarly), 32'd3);
        checkOutput("streamAccepts",   32'(accepts),    32'd6);
        checkOutput("streamOutputs",   32'(handshakes), 32'd2);
        checkOutput("streamMinGap",    32'(minGap),     32'd4);
        waitDrain();

        // Reset during ALIGN of the second term abandons the partial sum
        applyStimulus(32'h3F800000);
        applyStimulus(32'h3F800000);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstInReady",  {31'd0, in_ready},  32'd0);
        checkOutput("midRstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("midRstOutData",  out_data,           32'd0);
        checkOutput("midRstBusy",     {31'd0, busy},      32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sendGroup(32'h40000000, 32'h40000000, 32'h40000000, 32'h40C00000);
        waitDrain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
